// File: rtl/uop_pkg.sv
// Shared definitions for the microcode store and the microcode unit that fetches from it.
package uop_pkg;

  localparam int UOP_BUF_SIZE_DEFAULT  = 128;
  localparam int UOP_BUF_WIDTH_DEFAULT = 64;
  localparam int LD_WIDTH_DEFAULT      = 32;

  typedef enum logic [1:0] {
    S_LO   = 2'd0,
    S_HI   = 2'd1,
    S_DONE = 2'd2
  } uop_store_state_t;

  // A uop is assembled from exactly two loader beats.
  function automatic bit uop_width_ok(input int uop_width, input int ld_width);
    return uop_width == 2 * ld_width;
  endfunction

  function automatic bit uop_size_ok(input int size);
    return (size >= 2) && ((size & (size - 1)) == 0);
  endfunction

endpackage

// File: rtl/uop_store_if.sv
// Loader beat stream plus the fetch port of the microcode store.
interface uop_store_if
  import uop_pkg::*;
#(
  parameter int UOP_BUF_SIZE  = UOP_BUF_SIZE_DEFAULT,
  parameter int UOP_BUF_WIDTH = UOP_BUF_WIDTH_DEFAULT,
  parameter int LD_WIDTH      = LD_WIDTH_DEFAULT
);
  // Loader handshake: a beat transfers on a rising edge where ld_valid and
  // ld_ready are both high. ld_ready may drop combinationally with reload;
  // the loader keeps its beat stable until it sees it taken.
  logic                             ld_valid;
  logic                             ld_ready;
  logic [LD_WIDTH-1:0]              ld_data;
  logic                             ld_last;
  logic [$clog2(UOP_BUF_SIZE)-1:0]  uop_addr;
  logic [UOP_BUF_WIDTH-1:0]         uop;

  modport master (
    output ld_valid, ld_data, ld_last, uop_addr,
    input  ld_ready, uop
  );

  modport slave (
    input  ld_valid, ld_data, ld_last, uop_addr,
    output ld_ready, uop
  );
endinterface

// File: rtl/uop_store_mem.sv
// uop array with a per-entry valid vector; unwritten entries read as zero.
module uop_store_mem #(
  parameter int SIZE  = 128,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     we,
  input  logic [$clog2(SIZE)-1:0]  waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(SIZE)-1:0]  raddr,
  output logic [WIDTH-1:0]         rdata
);
  logic [WIDTH-1:0] mem_q [SIZE];
  logic [SIZE-1:0]  vld_q;
  logic [SIZE-1:0]  vld_d;

  // Array content survives reset and reload; vld alone decides visibility.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  always_comb begin
    vld_d = vld_q;
    if (clr) vld_d = '0;
    else if (we) vld_d[waddr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_q <= '0;
    else        vld_q <= vld_d;
  end

  assign rdata = vld_q[raddr] ? mem_q[raddr] : '0;

endmodule

// File: rtl/uop_store.sv
// Microcode store: loads an image from two-beat loader stream, serves fetches combinationally.
module uop_store
  import uop_pkg::*;
#(
  parameter int UOP_BUF_SIZE  = UOP_BUF_SIZE_DEFAULT,
  parameter int UOP_BUF_WIDTH = UOP_BUF_WIDTH_DEFAULT,
  parameter int LD_WIDTH      = LD_WIDTH_DEFAULT
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            reload,
  output logic                            loaded,
  output logic [$clog2(UOP_BUF_SIZE):0]   load_count,
  output uop_store_state_t                dbg_state,
  uop_store_if.slave                      bus
);
  localparam int AW = $clog2(UOP_BUF_SIZE);
  localparam int CW = AW + 1;

  if (!uop_width_ok(UOP_BUF_WIDTH, LD_WIDTH)) begin : g_bad_width
    $error("uop_store: UOP_BUF_WIDTH must be twice LD_WIDTH");
  end
  if (!uop_size_ok(UOP_BUF_SIZE)) begin : g_bad_size
    $error("uop_store: UOP_BUF_SIZE must be a power of two, at least 2");
  end

  uop_store_state_t     state_q, state_d;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [LD_WIDTH-1:0]  lo_q, lo_d;

  logic                      ld_ready;
  logic                      accept;
  logic                      mem_we;
  logic                      mem_clr;
  logic [UOP_BUF_WIDTH-1:0]  mem_wdata;

  assign ld_ready = (state_q != S_DONE) && !reload;
  assign accept   = bus.ld_valid && ld_ready;

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    cnt_d     = cnt_q;
    lo_d      = lo_q;
    mem_we    = 1'b0;
    mem_clr   = 1'b0;
    mem_wdata = '0;
    if (reload) begin
      state_d  = S_LO;
      wr_ptr_d = '0;
      cnt_d    = '0;
      lo_d     = '0;
      mem_clr  = 1'b1;
    end else if (accept) begin
      case (state_q)
        S_LO: begin
          lo_d = bus.ld_data;
          if (bus.ld_last) begin
            // A lone low beat closes the image with a zero high half.
            mem_we    = 1'b1;
            mem_wdata = {{LD_WIDTH{1'b0}}, bus.ld_data};
            wr_ptr_d  = wr_ptr_q + AW'(1);
            cnt_d     = cnt_q + CW'(1);
            state_d   = S_DONE;
          end else begin
            state_d = S_HI;
          end
        end
        S_HI: begin
          mem_we    = 1'b1;
          mem_wdata = {bus.ld_data, lo_q};
          wr_ptr_d  = wr_ptr_q + AW'(1);
          cnt_d     = cnt_q + CW'(1);
          // Writing the top entry ends the load even without ld_last; wr_ptr wraps unused.
          if (bus.ld_last || (wr_ptr_q == AW'(UOP_BUF_SIZE - 1))) state_d = S_DONE;
          else                                                    state_d = S_LO;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_LO;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      lo_q     <= lo_d;
    end
  end

  uop_store_mem #(
    .SIZE  (UOP_BUF_SIZE),
    .WIDTH (UOP_BUF_WIDTH)
  ) u_mem (
    .clk   (clk),
    .rst_n (reset),
    .clr   (mem_clr),
    .we    (mem_we),
    .waddr (wr_ptr_q),
    .wdata (mem_wdata),
    .raddr (bus.uop_addr),
    .rdata (bus.uop)
  );

  assign bus.ld_ready = ld_ready;
  assign loaded       = (state_q == S_DONE);
  assign load_count   = cnt_q;
  assign dbg_state    = state_q;

endmodule

// File: doc/uop_store.md
# uop_store

Microcode storage that serves the microcode unit's fetch side. The unit drives `uop_addr` and reads `uop` in the same cycle. A loader writes the store beforehand over a narrow valid/ready stream, assembling full-width uops from two half-width beats at consecutive addresses from 0. `loaded` gates release of the microcode unit's reset.

## Interface
Parameters:
- `UOP_BUF_SIZE`, default 128: number of uop entries; power of two, at least 2.
- `UOP_BUF_WIDTH`, default 64: uop width; must equal 2*`LD_WIDTH`.
- `LD_WIDTH`, default 32: loader beat width.

Ports:
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `uop_addr` input $clog2(UOP_BUF_SIZE): fetch address from the microcode unit.
- `uop` output UOP_BUF_WIDTH: combinational read data for `uop_addr`.
- `ld_valid` input 1: loader beat valid.
- `ld_ready` output 1: store accepts a beat.
- `ld_data` input LD_WIDTH: beat payload; low half of a uop first.
- `ld_last` input 1: qualifies the final beat of the image.
- `reload` input 1: single-cycle request to discard the image and restart loading.
- `loaded` output 1: image complete; high only in S_DONE.
- `load_count` output $clog2(UOP_BUF_SIZE)+1: number of uops written.

## Operation
- States are S_LO (expect low beat), S_HI (expect high beat) and S_DONE.
- `ld_ready` = (state != S_DONE) && !`reload`.
- A beat is accepted when `ld_valid && ld_ready`.
- S_LO accept:
  - Latch `ld_data` into `lo_reg`.
  - If `ld_last`, write {LD_WIDTH'0, ld_data} to `mem[wr_ptr]` and go to S_DONE.
  - Otherwise go to S_HI.
- S_HI accept:
  - Write {ld_data, lo_reg} to `mem[wr_ptr]` and set `vld[wr_ptr]`.
  - Increment `wr_ptr` and `load_count`.
  - Go to S_DONE if `ld_last` or `wr_ptr` == UOP_BUF_SIZE-1; otherwise go to S_LO.
- The S_LO `ld_last` write also sets `vld` and increments `wr_ptr` and `load_count`.
- Full store: after entry UOP_BUF_SIZE-1 is written, the FSM enters S_DONE regardless of `ld_last`. `wr_ptr` wraps to 0 and is not used again until reload. `load_count` = UOP_BUF_SIZE.
- Read: `uop` = `vld[uop_addr]` ? `mem[uop_addr]` : 0. An unwritten entry always reads as zero and never as X.
- Read/write same address, same cycle: `uop` shows the pre-write value (zero if not yet valid). The new value is visible the next cycle.
- `reload` (any state):
  - Next state is S_LO; `wr_ptr`, `load_count` and all `vld` bits clear.
  - `lo_reg` is discarded; `mem` contents are not cleared.
  - Any beat presented in the same cycle is not accepted, because `ld_ready` is low.
- S_DONE ignores `ld_valid` and holds all state until `reload`.

## Timing
- Reset values (asserted asynchronously while `reset`=0):
  - State S_LO; `wr_ptr`=0; `vld`=0; `lo_reg`=0.
  - `loaded`=0; `load_count`=0; `uop`=0 for every address.
  - `ld_ready`=1 unless `reload` is high. No beat is accepted while reset is held.
- Reset mid-load: partial image is lost; loading restarts at address 0 after release.
- Write latency: a uop becomes readable one cycle after its high (or last) beat is accepted.
- `loaded` rises in the cycle after the final accepting edge. It falls in the cycle after `reload` is sampled.
- Fetch latency is zero cycles (combinational), so the microcode unit sees no change in fetch timing.
- Back-to-back beats sustain one beat per cycle; the loader may deassert `ld_valid` at any time without penalty.

## Structure
- Shared package `uop_pkg`:
  - State enum `uop_store_state_t` (S_LO, S_HI, S_DONE).
  - `UOP_BUF_SIZE`/`UOP_BUF_WIDTH` defaults, shared with the microcode unit.
  - An elaboration-time check that `UOP_BUF_WIDTH == 2*LD_WIDTH`.
- One sub-module `uop_store_mem`: the array plus `vld` bit vector, with a write port, a combinational read port and a synchronous clear-all. The FSM, `lo_reg` and counters stay in `uop_store`.

## Test plan
- Reset then idle: all outputs equal their reset values; `uop_addr`=0..127 all read 0.
- Load 3 uops as 6 beats, last beat with `ld_last` (words 0x1111_1111_0000_0000, 0x2222…, 0x3333…): `uop` at addresses 0..2 matches; address 3 reads 0; `load_count`=3; `loaded`=1 one cycle after the 6th beat; `ld_ready`=0.
- `ld_last` on a low beat 0xDEADBEEF at address 0 -> `mem[0]`=0x0000_0000_DEAD_BEEF; `loaded`=1; `load_count`=1.
- 256 beats with no `ld_last` -> S_DONE after entry 127; `load_count`=128; a 257th beat is refused (`ld_ready`=0).
- Same-cycle read/write: hold `uop_addr`=0 while writing the high beat of uop 0 -> `uop`=0 that cycle and the new value next cycle.
- `reload` mid-S_HI with a beat presented in the same cycle -> beat dropped; `vld` cleared (address 0 reads 0). Asynchronous reset asserted mid-load -> outputs return to reset values immediately.
